// File: rtl/fpu_add_pkg.sv
// Shared types and constants for the fp32 adder scheduler.
package fpu_add_pkg;

   localparam int unsigned FPU_ADD_STAGES = 3;
   localparam int unsigned FPU_REQ_ID_W   = 1;

   typedef logic [31:0]             fp32_t;
   typedef logic [FPU_REQ_ID_W-1:0] req_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer only moves on an accepted transfer.
module rr_arb2 (
   input  logic       CLK,
   input  logic       nRST,
   input  logic [1:0] req,
   input  logic       accept,
   output logic [1:0] grant
);

   logic rr_q, rr_d;

   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = rr_q ? 2'b10 : 2'b01;
         default: grant = 2'b00;
      endcase
      // Point at the loser so it wins the next contention.
      rr_d = rr_q;
      if (accept) begin
         rr_d = ~grant[1];
      end
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         rr_q <= 1'b0;
      end else begin
         rr_q <= rr_d;
      end
   end

endmodule

// File: rtl/fpu_add_sched.sv
// Round-robin scheduler and 3-stage valid/tag pipeline controller for the shared fp32 adder.
// Define FPU_ADD_SCHED_PERF_EN to add saturating grant/stall performance counters.
module fpu_add_sched
   import fpu_add_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned STAGES  = FPU_ADD_STAGES
) (
   input  logic                  CLK,
   input  logic                  nRST,
   input  logic [NUM_REQ-1:0]    req_valid,
   output logic [NUM_REQ-1:0]    req_ready,
   input  fp32_t [NUM_REQ-1:0]   req_op1,
   input  fp32_t [NUM_REQ-1:0]   req_op2,
   output fp32_t                 dp_op1,
   output fp32_t                 dp_op2,
   output logic [STAGES-1:0]     stage_en,
   input  fp32_t                 dp_result,
   output logic                  out_valid,
   input  logic                  out_ready,
   output fp32_t                 out_result,
   output req_id_t               out_id,
   output logic                  busy
`ifdef FPU_ADD_SCHED_PERF_EN
   ,
   output logic [15:0]           perf_grant0,
   output logic [15:0]           perf_grant1,
   output logic [15:0]           perf_stall
`endif
);

   logic [2:0]     v_q, v_d;
   req_id_t [2:0]  id_q, id_d;
   logic           adv1, adv2, adv3;
   logic           s1_free, accept;
   logic [1:0]     grant;

   rr_arb2 u_arb (
      .CLK    (CLK),
      .nRST   (nRST),
      .req    (req_valid),
      .accept (accept),
      .grant  (grant)
   );

   // Ripple stall: a stage moves when the one ahead is empty or moving this cycle.
   always_comb begin
      adv3      = v_q[2] & out_ready;
      adv2      = v_q[1] & (~v_q[2] | adv3);
      adv1      = v_q[0] & (~v_q[1] | adv2);
      s1_free   = ~v_q[0] | adv1;
      req_ready = grant & {2{s1_free}};
      accept    = s1_free & (|grant);
      stage_en  = {adv2, adv1, accept};

      v_d[0] = accept | (v_q[0] & ~adv1);
      v_d[1] = adv1   | (v_q[1] & ~adv2);
      v_d[2] = adv2   | (v_q[2] & ~adv3);

      id_d = id_q;
      if (accept) id_d[0] = req_id_t'(grant[1]);
      if (adv1)   id_d[1] = id_q[0];
      if (adv2)   id_d[2] = id_q[1];
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         v_q  <= '0;
         id_q <= '0;
      end else begin
         v_q  <= v_d;
         id_q <= id_d;
      end
   end

   assign dp_op1     = grant[1] ? req_op1[1] : req_op1[0];
   assign dp_op2     = grant[1] ? req_op2[1] : req_op2[0];
   assign out_valid  = v_q[2];
   assign out_id     = id_q[2];
   assign out_result = dp_result;
   assign busy       = |v_q;

`ifdef FPU_ADD_SCHED_PERF_EN
   logic [15:0] grant0_q, grant1_q, stall_q;

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         grant0_q <= '0;
         grant1_q <= '0;
         stall_q  <= '0;
      end else begin
         if (accept && grant[0] && grant0_q != 16'hFFFF) grant0_q <= grant0_q + 16'd1;
         if (accept && grant[1] && grant1_q != 16'hFFFF) grant1_q <= grant1_q + 16'd1;
         if (v_q[2] && !out_ready && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
      end
   end

   assign perf_grant0 = grant0_q;
   assign perf_grant1 = grant1_q;
   assign perf_stall  = stall_q;
`endif

endmodule

// File: tb/tb_fpu_add_sched.sv
// Scoreboard bench for fpu_add_sched with a behavioural 3-stage adder datapath around it.
module tb_fpu_add_sched;
   import fpu_add_pkg::*;

   logic               CLK = 1'b0;
   logic               nRST;
   logic [1:0]         req_valid, req_ready;
   fp32_t [1:0]        req_op1, req_op2;
   fp32_t              dp_op1, dp_op2, dp_result, out_result;
   logic [2:0]         stage_en;
   logic               out_valid, out_ready, busy;
   req_id_t            out_id;
`ifdef FPU_ADD_SCHED_PERF_EN
   logic [15:0]        perf_grant0, perf_grant1, perf_stall;
`endif

   always #5 CLK = ~CLK;

   fpu_add_sched dut (
      .CLK        (CLK),
      .nRST       (nRST),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op1    (req_op1),
      .req_op2    (req_op2),
      .dp_op1     (dp_op1),
      .dp_op2     (dp_op2),
      .stage_en   (stage_en),
      .dp_result  (dp_result),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_id     (out_id),
`ifdef FPU_ADD_SCHED_PERF_EN
      .perf_grant0(perf_grant0),
      .perf_grant1(perf_grant1),
      .perf_stall (perf_stall),
`endif
      .busy       (busy)
   );

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct packed {
      logic        id;
      logic [31:0] res;
   } exp_t;
   exp_t sb[$];

   // Hand-computed IEEE sums for the directed pairs; other pairs use a cheap mixing function.
   function automatic logic [31:0] dp_fn(input logic [31:0] a, input logic [31:0] b);
      case ({a, b})
         {32'h3F80_0000, 32'h4000_0000}: return 32'h4040_0000; // 1.0 + 2.0
         {32'h3F80_0000, 32'h3F80_0000}: return 32'h4000_0000; // 1.0 + 1.0
         {32'h4000_0000, 32'h4000_0000}: return 32'h4080_0000; // 2.0 + 2.0
         {32'h3FC0_0000, 32'h4020_0000}: return 32'h4080_0000; // 1.5 + 2.5
         {32'h3F00_0000, 32'h3F00_0000}: return 32'h3F80_0000; // 0.5 + 0.5
         default:                        return a ^ {b[15:0], b[31:16]};
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural datapath: stage registers loaded only by the DUT's enables.
   logic [31:0] s1a = '0, s1b = '0, s2 = '0, s3 = '0;
   always @(posedge CLK) begin
      if (stage_en[0]) begin
         s1a <= dp_op1;
         s1b <= dp_op2;
      end
      if (stage_en[1]) s2 <= dp_fn(s1a, s1b);
      if (stage_en[2]) s3 <= s2;
   end
   assign dp_result = s3;

   // Issue side: record the expected result for each accepted transfer.
   always @(negedge CLK) begin : push_p
      exp_t e;
      if (nRST) begin
         chk("ready_onehot", 32'($countones(req_ready) <= 1), 32'h1);
         for (int i = 0; i < 2; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               e.id  = (i == 1);
               e.res = dp_fn(req_op1[i], req_op2[i]);
               sb.push_back(e);
            end
         end
      end
   end

   // Result side: every presented-and-taken result must match the oldest expectation.
   always @(negedge CLK) begin : pop_p
      exp_t e;
      if (nRST && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_unexpected: got result %08h id %0d, expected none", out_result,
                     out_id);
         end else begin
            e = sb.pop_front();
            chk("sb_id", 32'(out_id), 32'(e.id));
            chk("sb_result", out_result, e.res);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      step();
      nRST      = 1'b0;
      req_valid = 2'b00;
      out_ready = 1'b0;
      sb.delete();
      step();
      nRST = 1'b1;
   endtask

   logic [31:0] bp0;

   initial begin
      nRST       = 1'b0;
      req_valid  = 2'b00;
      out_ready  = 1'b0;
      req_op1[0] = 32'hA0A0_0001;
      req_op2[0] = 32'hB0B0_0002;
      req_op1[1] = 32'hC0C0_0003;
      req_op2[1] = 32'hD0D0_0004;
      step();
      @(negedge CLK);
      chk("rst_req_ready", 32'(req_ready), 32'h0);
      chk("rst_stage_en", 32'(stage_en), 32'h0);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_out_id", 32'(out_id), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_dp_op1", dp_op1, 32'hA0A0_0001);
      chk("rst_dp_op2", dp_op2, 32'hB0B0_0002);
      step();
      nRST = 1'b1;

      // Single op: 1.0 + 2.0 from requester 0.
      out_ready  = 1'b1;
      req_op1[0] = 32'h3F80_0000;
      req_op2[0] = 32'h4000_0000;
      req_valid  = 2'b01;
      @(negedge CLK);
      chk("single_ready", 32'(req_ready), 32'h1);
      chk("single_en0", 32'(stage_en), 32'h1);
      step();
      req_valid = 2'b00;
      @(negedge CLK);
      chk("single_en1", 32'(stage_en), 32'h2);
      chk("single_ov1", 32'(out_valid), 32'h0);
      step();
      @(negedge CLK);
      chk("single_en2", 32'(stage_en), 32'h4);
      chk("single_ov2", 32'(out_valid), 32'h0);
      step();
      @(negedge CLK);
      chk("single_ov3", 32'(out_valid), 32'h1);
      chk("single_id", 32'(out_id), 32'h0);
      chk("single_res", out_result, 32'h4040_0000);
      step();
      @(negedge CLK);
      chk("single_ov4", 32'(out_valid), 32'h0);
      chk("single_busy", 32'(busy), 32'h0);

      // Contention: both valid for 6 cycles, grants alternate starting at 0.
      do_reset();
      out_ready  = 1'b1;
      req_op1[0] = 32'h3F80_0000;
      req_op2[0] = 32'h3F80_0000;
      req_op1[1] = 32'h4000_0000;
      req_op2[1] = 32'h4000_0000;
      for (int c = 0; c < 10; c++) begin
         req_valid = (c < 6) ? 2'b11 : 2'b00;
         @(negedge CLK);
         if (c < 6) chk("cont_ready", 32'(req_ready), (c % 2 == 0) ? 32'h1 : 32'h2);
         chk("cont_ov", 32'(out_valid), 32'(c >= 3 && c <= 8));
         if (c >= 3 && c <= 8) chk("cont_id", 32'(out_id), 32'((c - 3) % 2));
         step();
      end

      // Back-pressure: fill with requester 1, hold 4 cycles, release with same-cycle accept.
      do_reset();
      req_valid = 2'b10;
      bp0       = dp_fn(32'h4100_0000, 32'h0001_0000);
      for (int c = 0; c < 13; c++) begin
         req_op1[1] = 32'h4100_0000 + 32'(c);
         req_op2[1] = 32'h0001_0000 * 32'(c + 1);
         out_ready  = (c >= 7);
         req_valid  = (c <= 7) ? 2'b10 : 2'b00;
         @(negedge CLK);
         if (c < 3) chk("bp_fill_ready", 32'(req_ready), 32'h2);
         if (c >= 3 && c <= 6) begin
            chk("bp_ready", 32'(req_ready), 32'h0);
            chk("bp_stage_en", 32'(stage_en), 32'h0);
            chk("bp_ov", 32'(out_valid), 32'h1);
            chk("bp_id", 32'(out_id), 32'h1);
            chk("bp_res", out_result, bp0);
         end
         if (c == 7) begin
            chk("bp_rel_ready", 32'(req_ready), 32'h2);
            chk("bp_rel_en", 32'(stage_en), 32'h7);
         end
         step();
      end
      @(negedge CLK);
      chk("bp_drained", 32'(sb.size()), 32'h0);
      chk("bp_busy", 32'(busy), 32'h0);

      // Fairness: blocked grants must not move the pointer.
      do_reset();
      req_op1[0] = 32'h3FC0_0000;
      req_op2[0] = 32'h4020_0000;
      req_op1[1] = 32'h3F00_0000;
      req_op2[1] = 32'h3F00_0000;
      for (int c = 0; c < 14; c++) begin
         out_ready = (c >= 7);
         req_valid = (c < 5) ? 2'b10 : (c < 9) ? 2'b11 : 2'b00;
         @(negedge CLK);
         if (c < 3) chk("fair_fill", 32'(req_ready), 32'h2);
         if (c >= 3 && c <= 6) chk("fair_blocked", 32'(req_ready), 32'h0);
         if (c == 7) chk("fair_rel0", 32'(req_ready), 32'h1);
         if (c == 8) chk("fair_rel1", 32'(req_ready), 32'h2);
         step();
      end
      @(negedge CLK);
      chk("fair_drained", 32'(sb.size()), 32'h0);

      // Reset with three ops in flight: nothing may come out afterwards.
      do_reset();
      req_op1[0] = 32'h3F80_0000;
      req_op2[0] = 32'h3F80_0000;
      req_valid  = 2'b01;
      for (int c = 0; c < 3; c++) step();
      req_valid = 2'b00;
      @(negedge CLK);
      chk("mid_busy_pre", 32'(busy), 32'h1);
      chk("mid_ov_pre", 32'(out_valid), 32'h1);
      step();
      nRST = 1'b0;
      sb.delete();
      step();
      nRST = 1'b1;
      @(negedge CLK);
      chk("mid_busy", 32'(busy), 32'h0);
      chk("mid_ov", 32'(out_valid), 32'h0);
      chk("mid_stage_en", 32'(stage_en), 32'h0);
      out_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         step();
         @(negedge CLK);
         chk("mid_no_stale", 32'(out_valid), 32'h0);
      end

`ifdef FPU_ADD_SCHED_PERF_EN
      do_reset();
      out_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         req_valid = (c < 4) ? 2'b01 : 2'b10;
         step();
      end
      req_valid = 2'b00;
      for (int c = 0; c < 5; c++) step();
      out_ready = 1'b0;
      for (int r = 0; r < 8; r++) begin
         req_valid = (r == 0) ? 2'b01 : 2'b00;
         out_ready = (r >= 6);
         step();
      end
      @(negedge CLK);
      chk("perf_grant0", 32'(perf_grant0), 32'd5);
      chk("perf_grant1", 32'(perf_grant1), 32'd2);
      chk("perf_stall", 32'(perf_stall), 32'd3);
      step();
      out_ready = 1'b0;
      req_valid = 2'b01;
      step();
      req_valid = 2'b00;
      repeat (70000) step();
      @(negedge CLK);
      chk("perf_stall_sat", 32'(perf_stall), 32'hFFFF);
      step();
      out_ready = 1'b1;
      for (int c = 0; c < 4; c++) step();
`endif

      @(negedge CLK);
      chk("final_sb_empty", 32'(sb.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
